alu_share_arbiter: RTL

- Shares the single 32-bit processor ALU between two requesters: port 0 is the multicycle datapath control, port 1 is the address/branch-target unit.
- Arbitrates round-robin and registers the granted operands and G_select onto the ALU inputs.
- Holds them for a fixed number of execute cycles, then captures the result and the C/V/N/Z flags.
- Returns the captured result and flags to the winning requester with a valid/ready handshake.

---
 rtl/alu_share_if.sv | 38 +++
 rtl/alu_share_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/alu_share_if.sv
// Request, response and ALU-side signals of the two-port ALU sharing arbiter.
// The slave view belongs to the arbiter; the master view to requesters and the ALU.
interface alu_share_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [2:0]       req0_sel;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [2:0]       req1_sel;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic [WIDTH-1:0] alu_a, alu_b, alu_g;
  logic [2:0]       alu_sel;
  logic             alu_c, alu_v, alu_n, alu_z;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp0_ready, rsp1_ready,
    input  alu_g, alu_c, alu_v, alu_n, alu_z,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_flags, alu_a, alu_b, alu_sel, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp0_ready, rsp1_ready,
    output alu_g, alu_c, alu_v, alu_n, alu_z,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_flags, alu_a, alu_b, alu_sel, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters:
// grant, hold operands for EXEC_CYCLES, capture result/flags, return via handshake.
module alu_share_arbiter #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  alu_share_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             win_q, win_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             grant0, grant1, rsp_hs;
  logic             req0_ready_c, req1_ready_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      win_q     <= 1'b0;
      cnt_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      res_q     <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    res_d        = res_q;
    flags_d      = flags_q;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;
    // ptr_q = 1 means port 1 is favoured when both ports are valid
    grant0       = bus.req0_valid && (!bus.req1_valid || !ptr_q);
    grant1       = bus.req1_valid && !grant0;
    rsp_hs       = win_q ? bus.rsp1_ready : bus.rsp0_ready;

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          req0_ready_c = grant0;
          req1_ready_c = grant1;
          alu_a_d      = grant1 ? bus.req1_a   : bus.req0_a;
          alu_b_d      = grant1 ? bus.req1_b   : bus.req0_b;
          alu_sel_d    = grant1 ? bus.req1_sel : bus.req0_sel;
          win_d        = grant1;
          cnt_d        = '0;
          ptr_d        = grant0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          res_d   = bus.alu_g;
          flags_d = {bus.alu_c, bus.alu_v, bus.alu_n, bus.alu_z};
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready = req0_ready_c;
  assign bus.req1_ready = req1_ready_c;
  assign bus.rsp0_valid = (state_q == RESP) && !win_q;
  assign bus.rsp1_valid = (state_q == RESP) &&  win_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.busy       = (state_q != IDLE);
endmodule
